// File: rtl/skip_adder_pipe.sv
// rtl/skip_adder_pipe.sv - pipelined carry-skip adder/subtractor with valid/ready stream handshake
module skip_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int GPS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_ci,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_s,
  output logic                     out_co,
  output logic                     out_ovf,
  output logic [WIDTH/BLOCK-1:0]   out_prop
);

  localparam int GROUPS = WIDTH / BLOCK;
  localparam int SW     = BLOCK * GPS;
  localparam int NSTG   = GROUPS / GPS;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Whole pipeline advances as one; a held output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int LO = k * SW;

    logic [SW-1:0]          cur_a;
    logic [SW-1:0]          cur_b;
    logic [SW-1:0]          s_n;
    logic [GPS-1:0]         p_n;
    logic                   cin;
    logic                   v_in;
    logic                   c_n;
    logic                   c_run;
    logic                   c_rip;
    logic [LO+SW-1:0]       s_all;
    logic [k*GPS+GPS-1:0]   p_all;
    logic [LO+SW-1:0]       s_q;
    logic [k*GPS+GPS-1:0]   p_q;
    logic                   c_q;
    logic                   v_q;

    if (k == 0) begin : g_first
      assign cur_a = in_a[SW-1:0];
      assign cur_b = b_eff[SW-1:0];
      assign cin   = in_sub | in_ci;
      assign v_in  = in_valid;
      assign s_all = s_n;
      assign p_all = p_n;
    end else begin : g_next
      assign cur_a = g_stage[k-1].g_fwd.a_q[SW-1:0];
      assign cur_b = g_stage[k-1].g_fwd.b_q[SW-1:0];
      assign cin   = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_all = {s_n, g_stage[k-1].s_q};
      assign p_all = {p_n, g_stage[k-1].p_q};
    end

    // Ripple inside each group; the group carry-out takes the skip path when all bits propagate.
    always_comb begin
      c_run = cin;
      c_rip = 1'b0;
      s_n   = '0;
      p_n   = '0;
      for (int g = 0; g < GPS; g++) begin
        c_rip = c_run;
        for (int j = 0; j < BLOCK; j++) begin
          s_n[g*BLOCK+j] = cur_a[g*BLOCK+j] ^ cur_b[g*BLOCK+j] ^ c_rip;
          c_rip = (cur_a[g*BLOCK+j] & cur_b[g*BLOCK+j]) |
                  (cur_a[g*BLOCK+j] & c_rip) |
                  (cur_b[g*BLOCK+j] & c_rip);
        end
        p_n[g] = &(cur_a[g*BLOCK +: BLOCK] ^ cur_b[g*BLOCK +: BLOCK]);
        c_run  = p_n[g] ? c_run : c_rip;
      end
      c_n = c_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
        p_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_n;
        s_q <= s_all;
        p_q <= p_all;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      localparam int REM = WIDTH - LO - SW;
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src0
        assign a_d = in_a[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_srcn
        assign a_d = g_stage[k-1].g_fwd.a_q[REM+SW-1:SW];
        assign b_d = g_stage[k-1].g_fwd.b_q[REM+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_n;
      logic ovf_q;

      // Carry into the MSB is recovered from its sum bit: c = s ^ a ^ b.
      assign ovf_n = cur_a[SW-1] ^ cur_b[SW-1] ^ s_n[SW-1] ^ c_n;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_n;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTG-1].v_q;
  assign out_s     = g_stage[NSTG-1].s_q;
  assign out_co    = g_stage[NSTG-1].c_q;
  assign out_prop  = g_stage[NSTG-1].p_q;
  assign out_ovf   = g_stage[NSTG-1].g_last.ovf_q;

endmodule
